// File: rtl/keypad_scanner.sv
// keypad_scanner: column-strobing scanner for a 4x4 keypad with debounce.
// One column is driven at a time. The row lines are synchronized and sampled once per
// column dwell. A single key is accepted only after DEBOUNCE matching samples and released
// only after DEBOUNCE all-zero samples. Bounce and multi-key patterns are rejected.
//
// Ports:
//   i_clk        system clock
//   i_reset      synchronous, active-high reset
//   i_row_in     raw row lines, active-high, asynchronous to i_clk
//   o_col_drive  one-hot column strobe to the keypad
//   o_row        one-hot row of the accepted key (0 when none held)
//   o_col        one-hot column of the accepted key (0 when none held)
//   o_key_valid  high while an accepted key is held
//   o_key_pulse  one-cycle strobe when a new press is accepted
module keypad_scanner #(
   parameter int unsigned SCAN_DIV = 1000,
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [3:0] i_row_in,
   output logic [3:0] o_col_drive,
   output logic [3:0] o_row,
   output logic [3:0] o_col,
   output logic       o_key_valid,
   output logic       o_key_pulse
);

   localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CntW = $clog2(DEBOUNCE + 1);
   localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE - 1);

   typedef enum logic [1:0] {StScan, StDebounce, StHeld} state_e;

   state_e          r_state, w_state_next;
   logic [3:0]      r_sync1, r_sync2;
   logic [DivW-1:0] r_div;
   logic [3:0]      r_col_drive, w_col_drive_next;
   logic [3:0]      r_cand_row, w_cand_row_next;
   logic [3:0]      r_cand_col, w_cand_col_next;
   logic [CntW-1:0] r_match, w_match_next;
   logic [CntW-1:0] r_release, w_release_next;
   logic [3:0]      r_row, w_row_next;
   logic [3:0]      r_col, w_col_next;
   logic            r_valid, w_valid_next;
   logic            r_pulse, w_pulse_next;

   logic            w_strobe;
   logic            w_one_hot;
   logic [3:0]      w_col_rot;

   // Sample at the end of the dwell so the rows have settled for the whole column period.
   assign w_strobe  = (r_div == DivLast);
   assign w_one_hot = (r_sync2 != 4'd0) && ((r_sync2 & (r_sync2 - 4'd1)) == 4'd0);
   assign w_col_rot = {r_col_drive[2:0], r_col_drive[3]};

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= StScan;
         r_sync1     <= '0;
         r_sync2     <= '0;
         r_div       <= '0;
         r_col_drive <= 4'b0001;
         r_cand_row  <= '0;
         r_cand_col  <= '0;
         r_match     <= '0;
         r_release   <= '0;
         r_row       <= '0;
         r_col       <= '0;
         r_valid     <= 1'b0;
         r_pulse     <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_sync1     <= i_row_in;
         r_sync2     <= r_sync1;
         r_div       <= w_strobe ? '0 : r_div + 1'b1;
         r_col_drive <= w_col_drive_next;
         r_cand_row  <= w_cand_row_next;
         r_cand_col  <= w_cand_col_next;
         r_match     <= w_match_next;
         r_release   <= w_release_next;
         r_row       <= w_row_next;
         r_col       <= w_col_next;
         r_valid     <= w_valid_next;
         r_pulse     <= w_pulse_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_col_drive_next = r_col_drive;
      w_cand_row_next  = r_cand_row;
      w_cand_col_next  = r_cand_col;
      w_match_next     = r_match;
      w_release_next   = r_release;
      w_row_next       = r_row;
      w_col_next       = r_col;
      w_valid_next     = r_valid;
      w_pulse_next     = 1'b0;

      if (w_strobe) begin
         unique case (r_state)
            StScan: begin
               if (w_one_hot) begin
                  w_cand_row_next = r_sync2;
                  w_cand_col_next = r_col_drive;
                  w_match_next    = CntW'(1);
                  if (DEBOUNCE == 1) begin
                     w_state_next   = StHeld;
                     w_release_next = '0;
                     w_row_next     = r_sync2;
                     w_col_next     = r_col_drive;
                     w_valid_next   = 1'b1;
                     w_pulse_next   = 1'b1;
                  end else begin
                     w_state_next = StDebounce;
                  end
               end else begin
                  w_col_drive_next = w_col_rot;
               end
            end
            StDebounce: begin
               if (r_sync2 == r_cand_row) begin
                  if (r_match == CntLast) begin
                     w_state_next   = StHeld;
                     w_match_next   = '0;
                     w_release_next = '0;
                     w_row_next     = r_cand_row;
                     w_col_next     = r_cand_col;
                     w_valid_next   = 1'b1;
                     w_pulse_next   = 1'b1;
                  end else begin
                     w_match_next = r_match + 1'b1;
                  end
               end else begin
                  w_match_next     = '0;
                  w_state_next     = StScan;
                  w_col_drive_next = w_col_rot;
               end
            end
            StHeld: begin
               // Any activity in the frozen column, even a different row, restarts release.
               if (r_sync2 == 4'd0) begin
                  if (r_release == CntLast) begin
                     w_release_next   = '0;
                     w_state_next     = StScan;
                     w_row_next       = '0;
                     w_col_next       = '0;
                     w_valid_next     = 1'b0;
                     w_col_drive_next = w_col_rot;
                  end else begin
                     w_release_next = r_release + 1'b1;
                  end
               end else begin
                  w_release_next = '0;
               end
            end
            default: w_state_next = StScan;
         endcase
      end
   end

   assign o_col_drive = r_col_drive;
   assign o_row       = r_row;
   assign o_col       = r_col;
   assign o_key_valid = r_valid;
   assign o_key_pulse = r_pulse;

endmodule
